// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - byte-serial copy/fill engine driving data_mem ports
//
// Purpose: copies a run of bytes (copy mode) or writes a constant over a run
// of addresses (fill mode), one byte at a time, and reports the modular sum
// of the bytes written.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   start, src_addr, dst_addr,   transfer request and its parameters,
//   length, fill_mode,           sampled only while idle
//   fill_value
//   busy, done, checksum         status; done pulses for one cycle
//   mem_read_select, mem_rdata   data_mem read port (combinational read)
//   mem_write_select, mem_wdata, data_mem write port
//   mem_write_en
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH-1:0] mem_read_select,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_write_select,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write_en
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  fill_q;
    logic [DATA_WIDTH-1:0] fill_value_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] checksum_q;
    logic [ADDR_WIDTH:0]   length_sat;

    assign length_sat = (length > DEPTH) ? DEPTH : length;
    assign checksum   = checksum_q;

    always_comb begin
        next_state       = state;
        busy             = 1'b0;
        done             = 1'b0;
        mem_read_select  = '0;
        mem_write_select = '0;
        mem_wdata        = '0;
        mem_write_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length_sat == '0)
                        next_state = DONE;
                    else if (fill_mode)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ: begin
                busy            = 1'b1;
                mem_read_select = cur_src;
                next_state      = WRITE;
            end
            WRITE: begin
                busy             = 1'b1;
                mem_write_select = cur_dst;
                mem_wdata        = fill_q ? fill_value_q : data_q;
                mem_write_en     = 1'b1;
                if (remaining == (ADDR_WIDTH+1)'(1))
                    next_state = DONE;
                else
                    next_state = fill_q ? WRITE : READ;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cur_src      <= '0;
            cur_dst      <= '0;
            remaining    <= '0;
            fill_q       <= 1'b0;
            fill_value_q <= '0;
            data_q       <= '0;
            acc          <= '0;
            checksum_q   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_src      <= src_addr;
                        cur_dst      <= dst_addr;
                        remaining    <= length_sat;
                        fill_q       <= fill_mode;
                        fill_value_q <= fill_value;
                        acc          <= '0;
                        // A zero-length transfer publishes an empty sum.
                        if (length_sat == '0)
                            checksum_q <= '0;
                    end
                end
                READ: data_q <= mem_rdata;
                WRITE: begin
                    acc       <= acc + mem_wdata;
                    cur_src   <= cur_src + 1'b1;
                    cur_dst   <= cur_dst + 1'b1;
                    remaining <= remaining - 1'b1;
                    // Publish on entry to DONE so the new sum is visible with done.
                    if (next_state == DONE)
                        checksum_q <= acc + mem_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] src_addr, dst_addr;
    logic [4:0] length;
    logic       fill_mode;
    logic [7:0] fill_value;
    logic       busy, done;
    logic [7:0] checksum;
    logic [3:0] mem_read_select, mem_write_select;
    logic [7:0] mem_rdata, mem_wdata;
    logic       mem_write_en;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [16];
    logic [7:0] init_img [16];
    logic       init_req = 1'b0;

    logic       we_log [64];
    logic [3:0] wa_log [64];
    logic       done_log [64];
    int         done_cyc;

    always #5 clock = ~clock;

    mem_copy_engine dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_mode(fill_mode), .fill_value(fill_value),
        .busy(busy), .done(done), .checksum(checksum),
        .mem_read_select(mem_read_select), .mem_rdata(mem_rdata),
        .mem_write_select(mem_write_select), .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en)
    );

    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
        end else if (mem_write_en) begin
            mem[mem_write_select] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_read_select];

    task automatic preload(input logic [7:0] base, input logic [7:0] step);
        @(negedge clock);
        for (int i = 0; i < 16; i++) init_img[i] = base + step * 8'(i);
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
    endtask

    // Pulses start in the cycle after the previous negedge and logs cycles
    // t+1.. until done; glitch_cyc > 0 re-pulses start in that cycle.
    task automatic run_transfer(input logic [3:0] s, input logic [3:0] d,
                                input logic [4:0] n, input logic f,
                                input logic [7:0] v, input int max_cyc,
                                input int glitch_cyc);
        for (int i = 0; i < 64; i++) begin
            we_log[i] = 1'b0; wa_log[i] = '0; done_log[i] = 1'b0;
        end
        done_cyc = 0;
        @(negedge clock);
        src_addr = s; dst_addr = d; length = n; fill_mode = f; fill_value = v;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == glitch_cyc) begin
                src_addr = 4'd0; dst_addr = 4'd0; length = 5'd1;
                fill_mode = 1'b1; fill_value = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            we_log[c] = mem_write_en;
            wa_log[c] = mem_write_select;
            done_log[c] = done;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_mode = 1'b0; fill_value = '0;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if ({busy, done, checksum, mem_read_select, mem_write_select, mem_wdata, mem_write_en} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b cs=%h rs=%h ws=%h wd=%h we=%b, expected all 0",
                     busy, done, checksum, mem_read_select, mem_write_select, mem_wdata, mem_write_en);
        end
        reset = 1'b0;
    endtask

    task automatic test_copy;
        logic [7:0] exp_mem [4];
        exp_mem = '{8'd7, 8'd3, 8'd2, 8'd1};
        preload(8'd0, 8'd0);
        @(negedge clock);
        init_img[0] = 8'd7; init_img[1] = 8'd3; init_img[2] = 8'd2; init_img[3] = 8'd1;
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
        run_transfer(4'd0, 4'd10, 5'd4, 1'b0, 8'h00, 30, 0);
        vectors++;
        if (done_cyc !== 9) begin
            miscompares++; $display("FAIL copy_done_cycle: got %0d, expected 9", done_cyc);
        end
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (we_log[c] !== (c == 2 || c == 4 || c == 6 || c == 8)) begin
                miscompares++; $display("FAIL copy_write_en c=%0d: got %b", c, we_log[c]);
            end
        end
        vectors++;
        if (checksum !== 8'd13) begin
            miscompares++; $display("FAIL copy_checksum: got %0d, expected 13", checksum);
        end
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[10+i] !== exp_mem[i]) begin
                miscompares++; $display("FAIL copy_mem[%0d]: got %0d, expected %0d", 10+i, mem[10+i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_fill_wrap;
        logic [3:0] exp_addr [4];
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        preload(8'd0, 8'd0);
        run_transfer(4'd0, 4'd14, 5'd4, 1'b1, 8'hAA, 30, 0);
        vectors++;
        if (done_cyc !== 5) begin
            miscompares++; $display("FAIL fill_done_cycle: got %0d, expected 5", done_cyc);
        end
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (we_log[c] !== 1'b1 || wa_log[c] !== exp_addr[c-1]) begin
                miscompares++; $display("FAIL fill_write c=%0d: got we=%b addr=%0d, expected we=1 addr=%0d",
                                        c, we_log[c], wa_log[c], exp_addr[c-1]);
            end
        end
        vectors++;
        if (checksum !== 8'hA8) begin
            miscompares++; $display("FAIL fill_checksum: got %h, expected a8", checksum);
        end
        @(negedge clock);
        vectors++;
        if (mem[14] !== 8'hAA || mem[15] !== 8'hAA || mem[0] !== 8'hAA || mem[1] !== 8'hAA || mem[2] !== 8'h00) begin
            miscompares++; $display("FAIL fill_mem: got %h %h %h %h %h, expected aa aa aa aa 00",
                                    mem[14], mem[15], mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_overlap;
        preload(8'd0, 8'd0);
        @(negedge clock);
        init_img[0] = 8'd7;
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
        run_transfer(4'd0, 4'd1, 5'd3, 1'b0, 8'h00, 30, 0);
        vectors++;
        if (checksum !== 8'd21 || done_cyc !== 7) begin
            miscompares++; $display("FAIL overlap_checksum: got cs=%0d done=%0d, expected cs=21 done=7", checksum, done_cyc);
        end
        @(negedge clock);
        vectors++;
        if (mem[1] !== 8'd7 || mem[2] !== 8'd7 || mem[3] !== 8'd7 || mem[4] !== 8'd0) begin
            miscompares++; $display("FAIL overlap_mem: got %0d %0d %0d %0d, expected 7 7 7 0", mem[1], mem[2], mem[3], mem[4]);
        end
    endtask

    task automatic test_length_bounds;
        int writes;
        run_transfer(4'd3, 4'd5, 5'd0, 1'b0, 8'h00, 10, 0);
        vectors++;
        if (done_cyc !== 1 || we_log[1] !== 1'b0 || checksum !== 8'd0) begin
            miscompares++; $display("FAIL len0: got done=%0d we=%b cs=%h, expected done=1 we=0 cs=00",
                                    done_cyc, we_log[1], checksum);
        end
        run_transfer(4'd0, 4'd0, 5'd20, 1'b1, 8'h01, 40, 0);
        writes = 0;
        for (int c = 1; c < 64; c++) if (we_log[c] === 1'b1) writes++;
        vectors++;
        if (writes !== 16 || done_cyc !== 17 || checksum !== 8'd16) begin
            miscompares++; $display("FAIL len_saturate: got writes=%0d done=%0d cs=%0d, expected 16 17 16",
                                    writes, done_cyc, checksum);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        preload(8'd1, 8'd1);
        @(negedge clock);
        for (int i = 4; i < 8; i++) init_img[i] = 8'd0;
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
        src_addr = 4'd0; dst_addr = 4'd4; length = 5'd4; fill_mode = 1'b0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clock);
        reset = 1'b1;           // held during cycle t+5
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || mem_write_en !== 1'b0 || checksum !== 8'd0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_outputs: got busy=%b we=%b cs=%h done=%b, expected 0 0 00 0",
                                    busy, mem_write_en, checksum, done);
        end
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (done !== 1'b0 || mem_write_en !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL reset_mid_quiet: got %0d active cycles, expected 0", bad);
        end
        vectors++;
        if (mem[4] !== 8'd1 || mem[5] !== 8'd2 || mem[6] !== 8'd0 || mem[7] !== 8'd0) begin
            miscompares++; $display("FAIL reset_mid_mem: got %0d %0d %0d %0d, expected 1 2 0 0", mem[4], mem[5], mem[6], mem[7]);
        end
    endtask

    task automatic test_back_to_back;
        preload(8'd1, 8'd1);
        run_transfer(4'd2, 4'd8, 5'd3, 1'b0, 8'h00, 30, 3);
        vectors++;
        if (done_cyc !== 7 || checksum !== 8'd12) begin
            miscompares++; $display("FAIL ignore_start: got done=%0d cs=%0d, expected 7 12", done_cyc, checksum);
        end
        run_transfer(4'd0, 4'd0, 5'd2, 1'b1, 8'h11, 30, 0);
        vectors++;
        if (done_cyc !== 3 || checksum !== 8'h22) begin
            miscompares++; $display("FAIL back_to_back: got done=%0d cs=%h, expected 3 22", done_cyc, checksum);
        end
        @(negedge clock);
        vectors++;
        if (mem[8] !== 8'd3 || mem[9] !== 8'd4 || mem[10] !== 8'd5 || mem[11] !== 8'd12 ||
            mem[0] !== 8'h11 || mem[1] !== 8'h11 || mem[2] !== 8'd3) begin
            miscompares++; $display("FAIL back_to_back_mem: got %0d %0d %0d %0d %h %h %0d, expected 3 4 5 12 11 11 3",
                                    mem[8], mem[9], mem[10], mem[11], mem[0], mem[1], mem[2]);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill_wrap();
        test_overlap();
        test_length_bounds();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
